// File: rtl/traffic_demand_detector_if.sv
// -----------------------------------------------------------------------------
// traffic_demand_detector_if
//   Groups the signals exchanged between the demand detector and its
//   surroundings: raw loop detectors and controller light codes going in,
//   demand flags, queue counts and the conflict fault coming out.
//
//   Signals:
//     loop_ns / loop_ew     raw loop detectors (asynchronous, high = vehicle)
//     light_ns / light_ew   controller light codes: 00 RED, 01 YELLOW,
//                           10 GREEN, 11 invalid
//     sensor_ns / sensor_ew heavy-traffic demand flags to the controller
//     queue_ns / queue_ew   queued-vehicle counts (QUEUE_W bits)
//     fault                 sticky light-conflict flag
//
//   Modports:
//     master  environment side (drives loops and lights)
//     slave   detector side (drives sensors, queues and fault)
// -----------------------------------------------------------------------------
interface traffic_demand_detector_if #(
   parameter int QUEUE_W = 6
);
   logic               loop_ns;
   logic               loop_ew;
   logic [1:0]         light_ns;
   logic [1:0]         light_ew;
   logic               sensor_ns;
   logic               sensor_ew;
   logic [QUEUE_W-1:0] queue_ns;
   logic [QUEUE_W-1:0] queue_ew;
   logic               fault;

   modport master (
      output loop_ns, loop_ew, light_ns, light_ew,
      input  sensor_ns, sensor_ew, queue_ns, queue_ew, fault
   );

   modport slave (
      input  loop_ns, loop_ew, light_ns, light_ew,
      output sensor_ns, sensor_ew, queue_ns, queue_ew, fault
   );
endinterface

// File: rtl/traffic_demand_detector.sv
// -----------------------------------------------------------------------------
// traffic_demand_detector
//   Produces the sensor_ns/sensor_ew demand inputs of the traffic light
//   controller. Per direction: synchronises and debounces the raw loop
//   detector, counts one arrival per debounced rising edge, discharges one
//   vehicle per DISCHARGE_CYCLES continuous green cycles, and raises a
//   heavy-traffic flag with HEAVY_ON/HEAVY_OFF hysteresis. A monitor latches
//   a sticky fault when both lights are non-RED or either shows code 11.
//
//   Ports:
//     clk    in   system clock, rising edge
//     reset  in   asynchronous active-low reset; clears all state and outputs
//     bus    slave modport of traffic_demand_detector_if (loops and lights in;
//            sensors, queues and fault out)
// -----------------------------------------------------------------------------
module traffic_demand_detector #(
   parameter int DEBOUNCE_CYCLES  = 4,
   parameter int QUEUE_W          = 6,
   parameter int HEAVY_ON         = 8,
   parameter int HEAVY_OFF        = 4,
   parameter int DISCHARGE_CYCLES = 10
) (
   input  logic                          clk,
   input  logic                          reset,
   traffic_demand_detector_if.slave      bus
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DT_W = $clog2(DISCHARGE_CYCLES + 1);

   localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DT_W-1:0]    DT_LAST   = DT_W'(DISCHARGE_CYCLES - 1);
   localparam logic [QUEUE_W-1:0] Q_MAX     = '1;
   localparam logic [QUEUE_W-1:0] Q_ZERO    = '0;
   localparam logic [QUEUE_W-1:0] TH_ON     = QUEUE_W'(HEAVY_ON);
   localparam logic [QUEUE_W-1:0] TH_OFF    = QUEUE_W'(HEAVY_OFF);

   localparam logic [1:0] LIGHT_RED     = 2'b00;
   localparam logic [1:0] LIGHT_GREEN   = 2'b10;
   localparam logic [1:0] LIGHT_INVALID = 2'b11;

   // -------------------------------------------------------------------------
   // Per-direction pipeline: index 0 = NS, index 1 = EW
   // -------------------------------------------------------------------------
   for (genvar gi = 0; gi < 2; gi++) begin : g_dir
      logic               loop_raw;
      logic [1:0]         light;

      logic               sync1_q, sync2_q;
      logic               deb_q, deb_d;
      logic               deb_dly_q;
      logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
      logic [DT_W-1:0]    dis_tmr_q, dis_tmr_d;
      logic [QUEUE_W-1:0] queue_q, queue_d;
      logic               sensor_q, sensor_d;
      logic               arrival;
      logic               departure;

      assign loop_raw = (gi == 0) ? bus.loop_ns  : bus.loop_ew;
      assign light    = (gi == 0) ? bus.light_ns : bus.light_ew;

      // Only a debounced rising edge counts; vehicles leaving are not events.
      assign arrival = deb_q & ~deb_dly_q;

      always_comb begin
         // Debounce: count consecutive cycles the synchronised input disagrees
         // with the debounced level; any agreement restarts the count.
         deb_d    = deb_q;
         db_cnt_d = db_cnt_q;
         if (sync2_q == deb_q) begin
            db_cnt_d = '0;
         end else if (db_cnt_q == DB_LAST) begin
            deb_d    = ~deb_q;
            db_cnt_d = '0;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end

         // Discharge: one departure per DISCHARGE_CYCLES unbroken green
         // cycles; any non-green cycle restarts the interval.
         departure = 1'b0;
         dis_tmr_d = dis_tmr_q;
         if (light != LIGHT_GREEN) begin
            dis_tmr_d = '0;
         end else if (dis_tmr_q == DT_LAST) begin
            dis_tmr_d = '0;
            departure = 1'b1;
         end else begin
            dis_tmr_d = dis_tmr_q + 1'b1;
         end

         // Simultaneous arrival and departure cancel; otherwise saturate at
         // both ends (a departure from an empty queue is simply dropped).
         queue_d = queue_q;
         case ({arrival, departure})
            2'b10:   if (queue_q != Q_MAX)  queue_d = queue_q + 1'b1;
            2'b01:   if (queue_q != Q_ZERO) queue_d = queue_q - 1'b1;
            default: queue_d = queue_q;
         endcase

         // Hysteresis on the registered queue, so the flag trails a threshold
         // crossing by one edge.
         sensor_d = sensor_q;
         if (queue_q >= TH_ON) begin
            sensor_d = 1'b1;
         end else if (queue_q <= TH_OFF) begin
            sensor_d = 1'b0;
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            db_cnt_q  <= '0;
            dis_tmr_q <= '0;
            queue_q   <= '0;
            sensor_q  <= 1'b0;
         end else begin
            sync1_q   <= loop_raw;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            db_cnt_q  <= db_cnt_d;
            dis_tmr_q <= dis_tmr_d;
            queue_q   <= queue_d;
            sensor_q  <= sensor_d;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Light conflict monitor
   // -------------------------------------------------------------------------
   logic fault_q, fault_d;
   logic conflict;

   assign conflict = ((bus.light_ns != LIGHT_RED) && (bus.light_ew != LIGHT_RED))
                   || (bus.light_ns == LIGHT_INVALID)
                   || (bus.light_ew == LIGHT_INVALID);

   always_comb begin
      fault_d = fault_q | conflict;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.queue_ns  = g_dir[0].queue_q;
   assign bus.queue_ew  = g_dir[1].queue_q;
   assign bus.sensor_ns = g_dir[0].sensor_q;
   assign bus.sensor_ew = g_dir[1].sensor_q;
   assign bus.fault     = fault_q;

endmodule
